// File: rtl/alu_ctl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctl_pkg
//
// Shared definitions for the ALU control decoder and the ALU it drives.
//   - ALU_Ctl select encodings (as localparams and as the alu_ctl_e enum)
//   - ALU_op operation-class codes from the main control unit
//   - R-type funct field codes recognised by the decoder
//   - op_class_ctl(): fixed ALU_Ctl for the non-R-type operation classes
// -----------------------------------------------------------------------------
package alu_ctl_pkg;

    localparam int unsigned FUNC_WIDTH = 6;
    localparam int unsigned CTL_WIDTH  = 4;
    localparam int unsigned OP_WIDTH   = 2;

    // ALU operation select encodings
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_AND  = 4'b0000;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_OR   = 4'b0001;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_ADD  = 4'b0010;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_XOR  = 4'b0011;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SUB  = 4'b0110;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SLT  = 4'b0111;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SLTU = 4'b1111;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SLL  = 4'b1000;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SRL  = 4'b1001;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_SRA  = 4'b1010;
    localparam logic [CTL_WIDTH-1:0] ALU_CTL_NOR  = 4'b1100;

    typedef enum logic [CTL_WIDTH-1:0] {
        CTL_AND  = ALU_CTL_AND,
        CTL_OR   = ALU_CTL_OR,
        CTL_ADD  = ALU_CTL_ADD,
        CTL_XOR  = ALU_CTL_XOR,
        CTL_SUB  = ALU_CTL_SUB,
        CTL_SLT  = ALU_CTL_SLT,
        CTL_SLTU = ALU_CTL_SLTU,
        CTL_SLL  = ALU_CTL_SLL,
        CTL_SRL  = ALU_CTL_SRL,
        CTL_SRA  = ALU_CTL_SRA,
        CTL_NOR  = ALU_CTL_NOR
    } alu_ctl_e;

    // ALU_op operation classes
    localparam logic [OP_WIDTH-1:0] ALU_OP_RTYPE = 2'b00;
    localparam logic [OP_WIDTH-1:0] ALU_OP_ADD   = 2'b01;  // load/store address
    localparam logic [OP_WIDTH-1:0] ALU_OP_SUB   = 2'b10;  // branch compare
    localparam logic [OP_WIDTH-1:0] ALU_OP_OR    = 2'b11;  // ori/lui path

    // R-type funct codes
    localparam logic [FUNC_WIDTH-1:0] FUNCT_ADD  = 6'b100000;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_ADDU = 6'b100001;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SUB  = 6'b100010;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SUBU = 6'b100011;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_AND  = 6'b100100;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_OR   = 6'b100101;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_XOR  = 6'b100110;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_NOR  = 6'b100111;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SLT  = 6'b101010;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SLTU = 6'b101011;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SLL  = 6'b000000;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SRL  = 6'b000010;
    localparam logic [FUNC_WIDTH-1:0] FUNCT_SRA  = 6'b000011;

    // Fixed select for the classes that ignore the funct field.
    // The R-type class is resolved by the funct decoder; its entry here
    // is the safe ADD default.
    function automatic alu_ctl_e op_class_ctl(input logic [OP_WIDTH-1:0] op);
        alu_ctl_e ctl;
        case (op)
            ALU_OP_ADD: ctl = CTL_ADD;
            ALU_OP_SUB: ctl = CTL_SUB;
            ALU_OP_OR:  ctl = CTL_OR;
            default:    ctl = CTL_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// -----------------------------------------------------------------------------
// alu_funct_decode
//
// Pure combinational lookup of the R-type funct field.
// Ports:
//   funct  in  6  instruction funct field [5:0]
//   ctl    out 4  ALU select for that funct (ADD for unknown codes)
//   legal  out 1  high when funct is one of the recognised R-type codes
// -----------------------------------------------------------------------------
module alu_funct_decode
    import alu_ctl_pkg::*;
(
    input  logic [FUNC_WIDTH-1:0] funct,
    output logic [CTL_WIDTH-1:0]  ctl,
    output logic                  legal
);

    alu_ctl_e ctl_e;

    always_comb begin
        ctl_e = CTL_ADD;
        legal = 1'b1;
        case (funct)
            FUNCT_ADD,
            FUNCT_ADDU: ctl_e = CTL_ADD;
            FUNCT_SUB,
            FUNCT_SUBU: ctl_e = CTL_SUB;
            FUNCT_AND:  ctl_e = CTL_AND;
            FUNCT_OR:   ctl_e = CTL_OR;
            FUNCT_XOR:  ctl_e = CTL_XOR;
            FUNCT_NOR:  ctl_e = CTL_NOR;
            FUNCT_SLT:  ctl_e = CTL_SLT;
            FUNCT_SLTU: ctl_e = CTL_SLTU;
            FUNCT_SLL:  ctl_e = CTL_SLL;
            FUNCT_SRL:  ctl_e = CTL_SRL;
            FUNCT_SRA:  ctl_e = CTL_SRA;
            default: begin
                // Unknown funct falls back to a harmless ADD.
                ctl_e = CTL_ADD;
                legal = 1'b0;
            end
        endcase
    end

    assign ctl = ctl_e;

endmodule

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
//
// MIPS-style ALU control decoder: maps the main decoder's ALU_op class and
// the R-type funct field to the 4-bit ALU select, and keeps a sticky flag
// recording any illegal R-type funct seen since the last clear.
//
// Ports:
//   clk         in  1       system clock, rising edge
//   reset_n     in  1       asynchronous active-low reset
//   FuncCode    in  FUNC_W  instruction funct field
//   ALU_op      in  2       operation class (00 R-type, 01 ADD, 10 SUB, 11 OR)
//   err_clr     in  1       synchronous clear of err_sticky (wins over illegal)
//   ALU_Ctl     out CTL_W   ALU operation select
//   illegal     out 1       R-type class with an unrecognised funct
//   err_sticky  out 1       registered sticky copy of illegal
//
// Build option:
//   ALU_CTL_REG_EN  when defined, ALU_Ctl and illegal are registered (one
//                   cycle latency, reset to ADD / 0). err_sticky always
//                   samples the combinational illegal.
// -----------------------------------------------------------------------------
module alu_control
    import alu_ctl_pkg::*;
#(
    parameter int unsigned FUNC_W = 6,
    parameter int unsigned CTL_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FUNC_W-1:0] FuncCode,
    input  logic [1:0]        ALU_op,
    input  logic              err_clr,
    output logic [CTL_W-1:0]  ALU_Ctl,
    output logic              illegal,
    output logic              err_sticky
);

    // The encodings are fixed by the instruction set; reject other widths.
    if (FUNC_W != FUNC_WIDTH) begin : g_bad_func_w
        $error("alu_control: FUNC_W must be 6");
    end
    if (CTL_W != CTL_WIDTH) begin : g_bad_ctl_w
        $error("alu_control: CTL_W must be 4");
    end

    logic [CTL_W-1:0] dec_ctl;
    logic             dec_legal;
    logic [CTL_W-1:0] ctl_comb;
    logic             illegal_comb;

    alu_funct_decode u_funct_decode (
        .funct (FuncCode),
        .ctl   (dec_ctl),
        .legal (dec_legal)
    );

    // Operation-class mux; only the R-type class can flag illegal.
    always_comb begin
        ctl_comb     = CTL_ADD;
        illegal_comb = 1'b0;
        if (ALU_op == ALU_OP_RTYPE) begin
            ctl_comb     = dec_ctl;
            illegal_comb = ~dec_legal;
        end else begin
            ctl_comb     = op_class_ctl(ALU_op);
        end
    end

    // Sticky error flag: clear has priority over a new illegal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end else if (illegal_comb) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef ALU_CTL_REG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ALU_Ctl <= CTL_ADD;
            illegal <= 1'b0;
        end else begin
            ALU_Ctl <= ctl_comb;
            illegal <= illegal_comb;
        end
    end
`else
    assign ALU_Ctl = ctl_comb;
    assign illegal = illegal_comb;
`endif

endmodule

// File: tb/tb_alu_control.sv
// -----------------------------------------------------------------------------
// tb_alu_control
//
// Self-checking bench for alu_control. Expected values come from a lookup
// table of the R-type funct codes and the fixed class codes. Works for both
// the default build and the ALU_CTL_REG_EN build.
// -----------------------------------------------------------------------------
module tb_alu_control;

    logic       clk;
    logic       reset_n;
    logic [5:0] FuncCode;
    logic [1:0] ALU_op;
    logic       err_clr;
    logic [3:0] ALU_Ctl;
    logic       illegal;
    logic       err_sticky;

    int unsigned checks;
    int unsigned failures;

    // funct -> ALU select, for recognised R-type codes only
    int unsigned rtype_tbl[int unsigned];

    alu_control #(.FUNC_W(6), .CTL_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .FuncCode   (FuncCode),
        .ALU_op     (ALU_op),
        .err_clr    (err_clr),
        .ALU_Ctl    (ALU_Ctl),
        .illegal    (illegal),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
        int unsigned key;
        key = int'(f);
        case (op)
            2'd1: return 4'b0010;
            2'd2: return 4'b0110;
            2'd3: return 4'b0001;
            default: begin
                if (rtype_tbl.exists(key)) return 4'(rtype_tbl[key]);
                return 4'b0010;
            end
        endcase
    endfunction

    function automatic logic exp_ill(input logic [1:0] op, input logic [5:0] f);
        int unsigned key;
        key = int'(f);
        return (op == 2'd0) && !rtype_tbl.exists(key);
    endfunction

    // Inputs are driven at a negedge; wait until outputs reflect them.
    task automatic settle();
`ifdef ALU_CTL_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        FuncCode = 6'b111111;
        ALU_op   = 2'b00;
        err_clr  = 1'b0;
        #1;
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_sticky: got %b want 0", err_sticky);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_sticky_hold: got %b want 0", err_sticky);
        end
`ifdef ALU_CTL_REG_EN
        checks++;
        if (ALU_Ctl !== 4'b0010 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ctl=%b ill=%b want ctl=0010 ill=0", ALU_Ctl, illegal);
        end
`else
        checks++;
        if (ALU_Ctl !== 4'b0010 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb: got ctl=%b ill=%b want ctl=0010 ill=1", ALU_Ctl, illegal);
        end
`endif
        @(negedge clk);
        FuncCode = 6'b100100;
        err_clr  = 1'b1;
        reset_n  = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
    endtask

    task automatic test_nor_wait();
        @(negedge clk);
        FuncCode = 6'b100111;
        ALU_op   = 2'b00;
        #100;
        checks++;
        if (ALU_Ctl !== 4'b1100 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL nor_wait: got ctl=%b ill=%b want ctl=1100 ill=0", ALU_Ctl, illegal);
        end
    endtask

    task automatic test_rtype_table();
        logic [5:0] fl[13];
        fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
               6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
               6'b000011};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ALU_op   = 2'b00;
            FuncCode = fl[i];
            settle();
            checks++;
            if (ALU_Ctl !== exp_ctl(2'b00, fl[i]) || illegal !== 1'b0) begin
                failures++;
                $display("FAIL rtype_%b: got ctl=%b ill=%b want ctl=%b ill=0",
                         fl[i], ALU_Ctl, illegal, exp_ctl(2'b00, fl[i]));
            end
        end
    endtask

    task automatic test_op_classes();
        logic [3:0] want[4];
        want = '{4'b1100, 4'b0010, 4'b0110, 4'b0001};
        for (int op = 1; op < 4; op++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                ALU_op   = 2'(op);
                FuncCode = (k == 0) ? 6'b100111 : 6'($urandom_range(0, 63));
                settle();
                checks++;
                if (ALU_Ctl !== want[op] || illegal !== 1'b0) begin
                    failures++;
                    $display("FAIL op_class_%0d funct=%b: got ctl=%b ill=%b want ctl=%b ill=0",
                             op, FuncCode, ALU_Ctl, illegal, want[op]);
                end
            end
        end
    endtask

    task automatic test_sticky_set();
        @(negedge clk);
        ALU_op   = 2'b00;
        FuncCode = 6'b111111;
        err_clr  = 1'b0;
        settle();
        checks++;
        if (ALU_Ctl !== 4'b0010 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_funct: got ctl=%b ill=%b want ctl=0010 ill=1", ALU_Ctl, illegal);
        end
        @(negedge clk);
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set: got %b want 1", err_sticky);
        end
        FuncCode = 6'b100100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (err_sticky !== 1'b1) begin
                failures++;
                $display("FAIL sticky_hold_%0d: got %b want 1", i, err_sticky);
            end
        end
        checks++;
        if (ALU_Ctl !== 4'b0000 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL sticky_and: got ctl=%b ill=%b want ctl=0000 ill=0", ALU_Ctl, illegal);
        end
    endtask

    task automatic test_clr_and_reset();
        @(negedge clk);
        ALU_op   = 2'b00;
        FuncCode = 6'b111110;
        err_clr  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL clr_pre: got %b want 1", err_sticky);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: got %b want 0", err_sticky);
        end
        @(negedge clk);
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: got %b want 1", err_sticky);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got %b want 0", err_sticky);
        end
`ifdef ALU_CTL_REG_EN
        checks++;
        if (ALU_Ctl !== 4'b0010 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_out: got ctl=%b ill=%b want ctl=0010 ill=0", ALU_Ctl, illegal);
        end
`else
        checks++;
        if (ALU_Ctl !== 4'b0010 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL comb_in_reset: got ctl=%b ill=%b want ctl=0010 ill=1", ALU_Ctl, illegal);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== 1'b1 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL first_edge: got sticky=%b ill=%b want sticky=1 ill=1", err_sticky, illegal);
        end
    endtask

    task automatic test_random();
        logic       exp_sticky;
        logic [3:0] exp_reg_ctl;
        logic       exp_reg_ill;
        logic [5:0] keys[13];
        keys = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                 6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                 6'b000011};
        // start from a known flag and a known registered output
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        exp_sticky  = 1'b0;
        exp_reg_ctl = exp_ctl(ALU_op, FuncCode);
        exp_reg_ill = exp_ill(ALU_op, FuncCode);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ALU_op   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ALU_op = 2'b00;
            FuncCode = ($urandom_range(0, 1) == 0) ? keys[$urandom_range(0, 12)]
                                                   : 6'($urandom_range(0, 63));
            err_clr  = ($urandom_range(0, 7) == 0);
            #1;
`ifdef ALU_CTL_REG_EN
            checks++;
            if (ALU_Ctl !== exp_reg_ctl || illegal !== exp_reg_ill) begin
                failures++;
                $display("FAIL rand_out_%0d: got ctl=%b ill=%b want ctl=%b ill=%b",
                         n, ALU_Ctl, illegal, exp_reg_ctl, exp_reg_ill);
            end
`else
            checks++;
            if (ALU_Ctl !== exp_ctl(ALU_op, FuncCode) || illegal !== exp_ill(ALU_op, FuncCode)) begin
                failures++;
                $display("FAIL rand_out_%0d op=%b f=%b: got ctl=%b ill=%b want ctl=%b ill=%b",
                         n, ALU_op, FuncCode, ALU_Ctl, illegal,
                         exp_ctl(ALU_op, FuncCode), exp_ill(ALU_op, FuncCode));
            end
`endif
            @(posedge clk);
            if (err_clr) exp_sticky = 1'b0;
            else if (exp_ill(ALU_op, FuncCode)) exp_sticky = 1'b1;
            exp_reg_ctl = exp_ctl(ALU_op, FuncCode);
            exp_reg_ill = exp_ill(ALU_op, FuncCode);
            #1;
            checks++;
            if (err_sticky !== exp_sticky) begin
                failures++;
                $display("FAIL rand_sticky_%0d: got %b want %b", n, err_sticky, exp_sticky);
            end
        end
        @(negedge clk);
        err_clr = 1'b0;
    endtask

`ifdef ALU_CTL_REG_EN
    task automatic test_reg_latency();
        @(negedge clk);
        ALU_op   = 2'b00;
        FuncCode = 6'b100100;
        @(posedge clk);
        @(negedge clk);
        FuncCode = 6'b100101;
        #1;
        checks++;
        if (ALU_Ctl !== 4'b0000) begin
            failures++;
            $display("FAIL reg_before_edge: got %b want 0000", ALU_Ctl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALU_Ctl !== 4'b0001) begin
            failures++;
            $display("FAIL reg_after_edge: got %b want 0001", ALU_Ctl);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rtype_tbl[32] = 2;   rtype_tbl[33] = 2;    // add, addu
        rtype_tbl[34] = 6;   rtype_tbl[35] = 6;    // sub, subu
        rtype_tbl[36] = 0;   rtype_tbl[37] = 1;    // and, or
        rtype_tbl[38] = 3;   rtype_tbl[39] = 12;   // xor, nor
        rtype_tbl[42] = 7;   rtype_tbl[43] = 15;   // slt, sltu
        rtype_tbl[0]  = 8;   rtype_tbl[2]  = 9;    // sll, srl
        rtype_tbl[3]  = 10;                        // sra

        test_reset();
        test_nor_wait();
        test_rtype_table();
        test_op_classes();
        test_sticky_set();
        test_clr_and_reset();
        test_random();
`ifdef ALU_CTL_REG_EN
        test_reg_latency();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- MIPS-style ALU control decoder that maps the 2-bit main-decoder ALU_op and the 6-bit R-type function field to a 4-bit ALU_Ctl select for the CPU execution unit's ALU.
- The decode path is purely combinational, with zero latency.
- A small clocked block holds a sticky illegal-funct error flag for debug and trap logic.

Parameters:
- FUNC_W, 6, width of FuncCode (fixed; checked at elaboration).
- CTL_W, 4, width of ALU_Ctl (fixed; checked at elaboration).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- FuncCode  in  6  instruction funct field [5:0].
- ALU_op  in  2  operation class from the main control unit.
- err_clr  in  1  synchronous clear for err_sticky.
- ALU_Ctl  out  4  ALU operation select.
- illegal  out  1  combinational; high when ALU_op=00 and FuncCode is not in the decode table.
- err_sticky  out  1  registered sticky copy of illegal.

Behaviour:
ALU_Ctl encodings:
- AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1111.
- SLL 1000, SRL 1001, SRA 1010, NOR 1100.

ALU_op classes:
- 00: R-type; decode FuncCode.
- 01: ADD (0010), for load/store address generation; FuncCode ignored.
- 10: SUB (0110), for branch compare; FuncCode ignored.
- 11: OR (0001), for ori/lui path; FuncCode ignored.

R-type FuncCode decode (ALU_op=00):
- 100000 and 100001 -> 0010 (add, addu).
- 100010 and 100011 -> 0110 (sub, subu).
- 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 1100.
- 101010 -> 0111; 101011 -> 1111.
- 000000 -> 1000; 000010 -> 1001; 000011 -> 1010.
- Any other value -> ALU_Ctl=0010 (safe ADD) and illegal=1.

Timing and output rules:
- ALU_Ctl and illegal are combinational from the inputs, with no clock dependence.
- ALU_Ctl and illegal are valid one delta after any input change, including while reset_n is low.
- illegal is 0 whenever ALU_op is not 00.

Error register:
- reset_n low: err_sticky=0 immediately (asynchronous).
- Rising clk edge with err_clr=1: err_sticky<=0.
- Rising clk edge with err_clr=0 and illegal=1: err_sticky<=1.
- err_clr has priority over a simultaneous illegal.
- Otherwise err_sticky holds.
- When reset_n deasserts, the first clock edge evaluates normally.

Other rules:
- X/Z on inputs does not need to be handled.
- No other state exists.

Optional Feature:
Macro ALU_CTL_REG_EN.
- Defined: ALU_Ctl and illegal are registered on the rising edge of clk, giving 1-cycle latency. Both reset asynchronously to 0010 and 0. err_sticky samples the combinational illegal, so it has the same timing as the undefined build.
- Undefined: both outputs are combinational, as described in Behaviour.

Decomposition:
- Package alu_ctl_pkg holds:
  - localparams for all ALU_Ctl encodings, the ALU_op class codes and the funct codes;
  - a typedef for the 4-bit control enum.
- The ALU imports the same package.
- One sub-module is natural: alu_funct_decode, a pure combinational FuncCode -> {ctl, legal} lookup.
- The top level adds the ALU_op mux, the sticky register and the optional output register.

Test Plan:
1. FuncCode=100111, ALU_op=00, reset_n=1, wait 100 ns -> ALU_Ctl=1100, illegal=0.
2. ALU_op=00 over every funct in the table -> the matching code. Check:
   - 100000 -> 0010
   - 100010 -> 0110
   - 101010 -> 0111
   - 000011 -> 1010
3. ALU_op=01, 10, 11 with FuncCode=100111 -> 0010, 0110, 0001 respectively; illegal=0.
4. ALU_op=00, FuncCode=111111 -> ALU_Ctl=0010, illegal=1; on the next clk edge err_sticky=1; it stays 1 after FuncCode returns to 100100.
5. With err_sticky=1:
   - err_clr=1 together with illegal=1 on the same edge -> err_sticky=0.
   - Assert reset_n=0 mid-cycle -> err_sticky=0 with no clock edge.
6. With ALU_CTL_REG_EN defined: change FuncCode from 100100 to 100101 -> ALU_Ctl changes 0000 -> 0001 only after the next rising clk edge; while reset_n=0, ALU_Ctl=0010.
